// File: rtl/xor_lane_pkg.sv
// Shared types and default geometry for the XOR lane packer.
// Contents: LANES/W defaults, lane/frame typedefs, packer state encoding.
package xor_lane_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned W     = 2;

    typedef logic [W-1:0] lane_t;
    typedef lane_t frame_t [0:LANES-1];

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

endpackage

// File: rtl/xor_lane_counter.sv
// Lane index counter for the packer: increments per accepted element,
// clears on frame close, and flags the last lane of a frame.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   inc_i       advance to next lane
//   clr_i       return to lane 0 (wins over inc_i)
//   idx_o       current lane index
//   term_o      registered flag, idx_o == LANES-1
module xor_lane_counter #(
    parameter int unsigned LANES = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             term_o
);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             term_q;

    // Next index
    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // Terminal flag is registered from the next index so it lines up with idx_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            term_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            term_q <= (idx_d == IDX_W'(LANES - 1));
        end
    end

    assign idx_o  = idx_q;
    assign term_o = term_q;

endmodule

// File: rtl/xor_lane_packer.sv
// Upstream feeder for the XOR lane stage. Collects LANES W-bit elements
// into a frame (lane 0 first) and presents it on a registered output slot.
// A second frame may close while the slot is occupied; it waits in the
// assembly register (HOLD) so the stream sustains one element per cycle.
// Short frames (closed by in_last early) are zero-padded and flagged.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     element handshake (in_ready decodes the state register)
//   in_data, in_last      element and frame-close marker
//   out_valid/out_ready   frame handshake
//   out_data, out_short   held frame and short-frame flag
//   out_parity            even parity of the frame (XOR_LANE_PACKER_PARITY_EN only)
// Configuration macro: XOR_LANE_PACKER_PARITY_EN
module xor_lane_packer #(
    parameter int unsigned LANES = xor_lane_pkg::LANES,
    parameter int unsigned W     = xor_lane_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data [0:LANES-1],
    output logic         out_short
`ifdef XOR_LANE_PACKER_PARITY_EN
    ,
    output logic         out_parity
`endif
);

    import xor_lane_pkg::*;

    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    pack_state_t      state_q;
    pack_state_t      state_d;
    logic [W-1:0]     asm_q      [0:LANES-1];
    logic [W-1:0]     asm_d      [0:LANES-1];
    logic [W-1:0]     frame_c    [0:LANES-1];
    logic [W-1:0]     out_data_q [0:LANES-1];
    logic [W-1:0]     out_data_d [0:LANES-1];
    logic             out_valid_q;
    logic             out_valid_d;
    logic             out_short_q;
    logic             out_short_d;
    logic             hold_short_q;
    logic             hold_short_d;

    logic [IDX_W-1:0] idx;
    logic             idx_term;
    logic             accept;
    logic             close;
    logic             short_c;
    logic             slot_free;
    logic             cnt_inc;
    logic             cnt_clr;

`ifdef XOR_LANE_PACKER_PARITY_EN
    logic             out_parity_q;
    logic             out_parity_d;
    logic             frame_par_c;
    logic             asm_par_c;
`endif

    xor_lane_counter #(
        .LANES (LANES),
        .IDX_W (IDX_W)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (cnt_inc),
        .clr_i  (cnt_clr),
        .idx_o  (idx),
        .term_o (idx_term)
    );

    assign in_ready  = (state_q == FILL);
    assign accept    = in_valid & in_ready;
    assign close     = accept & (in_last | idx_term);
    assign short_c   = in_last & ~idx_term;
    assign slot_free = ~out_valid_q | out_ready;

    // Closing frame: earlier lanes from assembly, new element at idx, rest zero
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (IDX_W'(i) < idx) begin
                frame_c[i] = asm_q[i];
            end else if (IDX_W'(i) == idx) begin
                frame_c[i] = in_data;
            end else begin
                frame_c[i] = '0;
            end
        end
    end

`ifdef XOR_LANE_PACKER_PARITY_EN
    // Parity of the frame leaving directly and of the frame waiting in HOLD
    always_comb begin
        frame_par_c = 1'b0;
        asm_par_c   = 1'b0;
        for (int i = 0; i < int'(LANES); i++) begin
            frame_par_c = frame_par_c ^ (^frame_c[i]);
            asm_par_c   = asm_par_c ^ (^asm_q[i]);
        end
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        asm_d        = asm_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_short_d  = out_short_q;
        hold_short_d = hold_short_q;
        cnt_inc      = 1'b0;
        cnt_clr      = 1'b0;
`ifdef XOR_LANE_PACKER_PARITY_EN
        out_parity_d = out_parity_q;
`endif
        case (state_q)
            FILL: begin
                if (close) begin
                    cnt_clr = 1'b1;
                    if (slot_free) begin
                        out_data_d  = frame_c;
                        out_short_d = short_c;
                        out_valid_d = 1'b1;
`ifdef XOR_LANE_PACKER_PARITY_EN
                        out_parity_d = frame_par_c;
`endif
                        for (int i = 0; i < int'(LANES); i++) begin
                            asm_d[i] = '0;
                        end
                    end else begin
                        // Output slot busy: park the finished frame and stall input
                        asm_d        = frame_c;
                        hold_short_d = short_c;
                        state_d      = HOLD;
                    end
                end else begin
                    if (accept) begin
                        cnt_inc    = 1'b1;
                        asm_d[idx] = in_data;
                    end
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_data_d  = asm_q;
                    out_short_d = hold_short_q;
                    out_valid_d = 1'b1;
`ifdef XOR_LANE_PACKER_PARITY_EN
                    out_parity_d = asm_par_c;
`endif
                    for (int i = 0; i < int'(LANES); i++) begin
                        asm_d[i] = '0;
                    end
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State, assembly and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            out_valid_q  <= 1'b0;
            out_short_q  <= 1'b0;
            hold_short_q <= 1'b0;
            for (int i = 0; i < int'(LANES); i++) begin
                asm_q[i]      <= '0;
                out_data_q[i] <= '0;
            end
`ifdef XOR_LANE_PACKER_PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_short_q  <= out_short_d;
            hold_short_q <= hold_short_d;
            for (int i = 0; i < int'(LANES); i++) begin
                asm_q[i]      <= asm_d[i];
                out_data_q[i] <= out_data_d[i];
            end
`ifdef XOR_LANE_PACKER_PARITY_EN
            out_parity_q <= out_parity_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_short = out_short_q;
    assign out_data  = out_data_q;
`ifdef XOR_LANE_PACKER_PARITY_EN
    assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_xor_lane_packer.sv
// Scoreboard bench for xor_lane_packer: accepted elements are grouped into
// expected frames by a reference model; a monitor compares every delivered
// frame and checks output stability while the downstream stalls.
`timescale 1ns/1ps
module tb_xor_lane_packer;

    localparam int LANES = 4;
    localparam int W     = 2;
    localparam int FW    = LANES * W;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         in_last   = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         out_short;
    logic [W-1:0] out_data [0:LANES-1];
`ifdef XOR_LANE_PACKER_PARITY_EN
    logic         out_parity;
`endif

    always #5 clk = ~clk;

    xor_lane_packer #(
        .LANES (LANES),
        .W     (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_short (out_short)
`ifdef XOR_LANE_PACKER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    typedef struct {
        logic [FW-1:0] data;
        logic          short_f;
    } exp_t;

    exp_t          exp_q[$];
    logic [W-1:0]  part [0:LANES-1];
    int            part_n      = 0;
    int            total       = 0;
    int            bad         = 0;
    int            cyc         = 0;
    logic          last_acc    = 1'b0;
    bit            watch       = 1'b0;
    bit            rand_mode   = 1'b0;
    int            ready_drops = 0;
    int            hs_cyc[$];
    logic          stall       = 1'b0;
    logic [FW-1:0] stall_data  = '0;
    logic          stall_short = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] pack_out();
        logic [FW-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*W +: W] = out_data[i];
        return v;
    endfunction

    // Monitor and reference model, sampled 1 ns before each rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (!rst_n) begin
                last_acc = 1'b0;
                part_n   = 0;
                stall    = 1'b0;
                exp_q.delete();
                continue;
            end
            if (out_valid) begin
                if (stall) begin
                    chk("stall_data", 32'(pack_out()), 32'(stall_data));
                    chk("stall_short", 32'(out_short), 32'(stall_short));
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_data", 32'(pack_out()), 32'(e.data));
                        chk("frame_short", 32'(out_short), 32'(e.short_f));
`ifdef XOR_LANE_PACKER_PARITY_EN
                        chk("frame_parity", 32'(out_parity), 32'(^e.data));
`endif
                    end
                    if (watch) hs_cyc.push_back(cyc);
                end
            end
            stall       = out_valid && !out_ready;
            stall_data  = pack_out();
            stall_short = out_short;
            if (watch && !in_ready) ready_drops++;
            last_acc = in_valid && in_ready;
            if (last_acc) begin
                part[part_n] = in_data;
                part_n++;
                if (in_last || part_n == LANES) begin
                    e.data = '0;
                    for (int i = 0; i < part_n; i++) e.data[i*W +: W] = part[i];
                    e.short_f = (part_n < LANES);
                    exp_q.push_back(e);
                    part_n = 0;
                end
            end
        end
    end

    // Random downstream back-pressure
    initial begin
        forever begin
            @(negedge clk);
            if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [W-1:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            @(negedge clk);
            n++;
        end while (!last_acc && n < 200);
        if (!last_acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept after %0d cycles", n);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset values
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_short", 32'(out_short), 0);
        chk("rst_out_data", 32'(pack_out()), 0);
`ifdef XOR_LANE_PACKER_PARITY_EN
        chk("rst_out_parity", 32'(out_parity), 0);
`endif
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Full frame {1,2,3,0}; one-cycle latency after the closing element
        send(2'd1, 1'b0);
        send(2'd2, 1'b0);
        send(2'd3, 1'b0);
        chk("lat_before_close", 32'(out_valid), 0);
        send(2'd0, 1'b0);
        chk("lat_after_close", 32'(out_valid), 1);
        idle(3);

        // Short frames: {3,2,0,0}, {1,0,0,0}, then a full frame closed by in_last
        send(2'd3, 1'b0);
        send(2'd2, 1'b1);
        idle(2);
        send(2'd1, 1'b1);
        idle(2);
        send(2'd2, 1'b0);
        send(2'd1, 1'b0);
        send(2'd3, 1'b0);
        send(2'd3, 1'b1);
        idle(3);

        // Back-pressure: second frame waits in HOLD, input stalls
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(W'($urandom), 1'b0);
        idle(0);
        chk("hold_in_ready", 32'(in_ready), 0);
        chk("hold_out_valid", 32'(out_valid), 1);
        idle(3);
        out_ready = 1'b1;
        idle(5);
        chk("hold_release_ready", 32'(in_ready), 1);

        // Continuous stream: in_ready stays high, one frame every 4 cycles
        watch = 1'b1;
        for (int i = 0; i < 12; i++) send(W'($urandom), 1'b0);
        idle(6);
        watch = 1'b0;
        chk("stream_ready_drops", 32'(ready_drops), 0);
        chk("stream_frames", 32'(hs_cyc.size()), 3);
        for (int i = 0; i + 1 < hs_cyc.size(); i++)
            chk("stream_gap", 32'(hs_cyc[i+1] - hs_cyc[i]), 4);

        // Reset mid-frame discards the partial frame
        send(2'd2, 1'b0);
        send(2'd1, 1'b0);
        idle(1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_short", 32'(out_short), 0);
        chk("mid_rst_out_data", 32'(pack_out()), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(2'd3, 1'b0);
        send(2'd3, 1'b0);
        send(2'd1, 1'b0);
        send(2'd2, 1'b0);
        idle(4);

        // Randomized traffic with random back-pressure
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            idle(int'($urandom_range(0, 2)));
            send(W'($urandom), ($urandom_range(0, 3) == 0));
        end
        idle(0);
        rand_mode = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        idle(10);
        chk("sb_drain", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
